oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
//  Sequences sprite DMA ($4014): copies one 256-byte page from the 2 KB work RAM into PPU OAM.
//  Owns the single WRAM port and shares it: the CPU passes straight through when idle and the DMA
//  engine takes the port while busy. Sits between the CPU bus decoder, the WRAM and the PPU OAM port.
//  One clk = one CPU cycle.
// PARAMETERS
//  ADDR_WIDTH  11   WRAM address width (2 KB; pages $00-$1F mirror every 8 pages)
//  DATA_WIDTH  8    data bus width
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  cpu_wram_en  in   1   CPU WRAM select (decoded $0000-$1FFF)
//  cpu_rw       in   1   CPU read/write: 1 = read, 0 = write (WRAM write strobe when 0)
//  cpu_addr     in   11  CPU WRAM address
//  cpu_din      in   8   CPU write data
//  dma_start    in   1   one-cycle strobe: CPU write to $4014
//  dma_page     in   8   source page, valid with dma_start
//  wram_en      out  1   WRAM chip enable
//  wram_rw      out  1   WRAM read/write select (same encoding as cpu_rw)
//  wram_addr    out  11  WRAM address
//  wram_din     out  8   WRAM write data
//  wram_dout    in   8   WRAM read data (valid the cycle after the address, while wram_en=1)
//  cpu_rdy      out  1   0 = CPU halted by DMA
//  dma_busy     out  1   transfer in progress
//  dma_err      out  1   one-cycle pulse: unsupported source page
//  oam_wr       out  1   OAM write strobe (PPU auto-increments OAMADDR)
//  oam_data     out  8   OAM write data
// BEHAVIOUR
//  Reset: state=IDLE, byte counter=0, parity=0; cpu_rdy=1, dma_busy=0, dma_err=0, oam_wr=0,
//   oam_data=0; wram_* follow the CPU inputs (pass-through).
//  Parity flop toggles every clk from reset (0 = even cycle).
//  IDLE: wram_en/rw/addr/din = cpu_* combinationally (0 latency).
//   dma_start with dma_page<$20: latch page[2:0] -> HALT.
//   dma_start with dma_page>=$20: dma_err=1 for one cycle, stay IDLE, cpu_rdy stays 1.
//  HALT (1 cycle): cpu_rdy=0, dma_busy=1, wram_en=0. -> ALIGN or READ (see CONFIGURATION).
//  ALIGN (1 cycle): as HALT. -> READ.
//  READ: wram_en=1, wram_rw=1, wram_addr={page[2:0],cnt[7:0]}. -> WRITE.
//  WRITE: same wram_en/rw/addr held so wram_dout stays valid; oam_wr=1, oam_data=wram_dout.
//   cnt==255: cnt<=0, -> IDLE; else cnt<=cnt+1, -> READ.
//  cpu_rdy=0 and dma_busy=1 in every non-IDLE state; CPU WRAM requests ignored (not queued)
//   while busy; CPU must not rely on rdy to retry writes.
//  oam_wr/oam_data combinational from state; oam_data=0 outside WRITE.
//  dma_start while busy: ignored (no restart, no error).
//  Transfer length: 1 + 512 cycles busy (513); cpu_rdy returns 1 the cycle after the last WRITE.
//  cnt 8 bits, wraps 255->0 only at transfer end; page address never crosses page boundary.
//  rst mid-transfer: immediate return to IDLE, oam_wr=0, partial OAM contents left as written.
// CONFIGURATION
//  DMA_ODD_ALIGN_EN defined: if the HALT cycle falls on an odd cycle (parity=1), insert ALIGN
//   -> 514 busy cycles; even -> 513.
//  DMA_ODD_ALIGN_EN undefined: ALIGN unreachable; always 513 busy cycles.
// TESTING
//  1. Assert rst mid-sim -> cpu_rdy=1, dma_busy=0, oam_wr=0, oam_data=0, wram_* == cpu_* same cycle.
//  2. Idle CPU write addr 11'h123 data 8'hA5 then read -> wram pass-through, read returns 8'hA5.
//  3. Preload WRAM[$200+i]=i^8'h5A, dma_start page=$02 -> 256 oam_wr pulses, data i^8'h5A in
//     order, cpu_rdy low exactly 513 cycles (macro off).
//  4. dma_start page=$0A -> reads WRAM $200-$2FF (mirror); page=$40 -> single dma_err pulse,
//     zero oam_wr, cpu_rdy never low.
//  5. rst asserted after 100th oam_wr -> next cycle IDLE, cpu_rdy=1; new dma_start runs full 256.
//  6. Macro on: start on even parity -> 513 busy; start on odd -> 514; second dma_start while
//     busy -> ignored.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_ctrl
// Description : Sprite DMA sequencer for $4014. Copies one 256-byte WRAM page
//               into PPU OAM and arbitrates the single WRAM port between the
//               CPU (pass-through while idle) and the DMA engine (while busy).
//               One clk equals one CPU cycle.
//               Optional feature macro: DMA_ODD_ALIGN_EN inserts an ALIGN
//               cycle when the HALT cycle lands on an odd CPU cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_wram_en,
  input  logic                  cpu_rw,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  input  logic                  dma_start,
  input  logic [7:0]            dma_page,
  output logic                  wram_en,
  output logic                  wram_rw,
  output logic [ADDR_WIDTH-1:0] wram_addr,
  output logic [DATA_WIDTH-1:0] wram_din,
  input  logic [DATA_WIDTH-1:0] wram_dout,
  output logic                  cpu_rdy,
  output logic                  dma_busy,
  output logic                  dma_err,
  output logic                  oam_wr,
  output logic [DATA_WIDTH-1:0] oam_data
);

  // Page bits that actually address the 2 KB RAM; higher page bits mirror.
  localparam int         c_PAGE_BITS  = ADDR_WIDTH - 8;
  localparam logic [7:0] c_PAGE_LIMIT = 8'h20;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_HALT  = 3'd1;
  localparam logic [2:0] c_ALIGN = 3'd2;
  localparam logic [2:0] c_READ  = 3'd3;
  localparam logic [2:0] c_WRITE = 3'd4;

  logic [2:0]             r_state;
  logic [2:0]             w_next;
  logic [7:0]             r_cnt;
  logic [c_PAGE_BITS-1:0] r_page;
  logic                   r_dma_err;
  logic                   w_start_ok;
  logic                   w_start_bad;
  logic [ADDR_WIDTH-1:0]  w_dma_addr;

  // Starts are only honoured in IDLE; a start while busy is silently dropped.
  assign w_start_ok  = (r_state == c_IDLE) && dma_start && (dma_page <  c_PAGE_LIMIT);
  assign w_start_bad = (r_state == c_IDLE) && dma_start && (dma_page >= c_PAGE_LIMIT);
  assign w_dma_addr  = {r_page, r_cnt};
  assign dma_err     = r_dma_err;

`ifdef DMA_ODD_ALIGN_EN
  logic r_parity;

  // CPU cycle parity (0 = even); only the align decision consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ~r_parity;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // Byte counter, latched source page and registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 8'd0;
      r_page    <= '0;
      r_dma_err <= 1'b0;
    end else begin
      r_dma_err <= w_start_bad;
      if (w_start_ok) begin
        r_page <= dma_page[c_PAGE_BITS-1:0];
      end
      // 255 -> 0 wrap coincides with the final WRITE, leaving cnt=0 for the next run.
      if (r_state == c_WRITE) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_start_ok) w_next = c_HALT;
`ifdef DMA_ODD_ALIGN_EN
      c_HALT:  w_next = r_parity ? c_ALIGN : c_READ;
`else
      c_HALT:  w_next = c_READ;
`endif
      c_ALIGN: w_next = c_READ;
      c_READ:  w_next = c_WRITE;
      c_WRITE: w_next = (r_cnt == 8'hFF) ? c_IDLE : c_READ;
      default: w_next = c_IDLE;
    endcase
  end

  // Output decode: CPU owns the WRAM port in IDLE, DMA owns it otherwise.
  always_comb begin
    wram_en   = 1'b0;
    wram_rw   = 1'b1;
    wram_addr = w_dma_addr;
    wram_din  = '0;
    cpu_rdy   = 1'b0;
    dma_busy  = 1'b1;
    oam_wr    = 1'b0;
    oam_data  = '0;
    case (r_state)
      c_IDLE: begin
        wram_en   = cpu_wram_en;
        wram_rw   = cpu_rw;
        wram_addr = cpu_addr;
        wram_din  = cpu_din;
        cpu_rdy   = 1'b1;
        dma_busy  = 1'b0;
      end
      c_READ: begin
        wram_en = 1'b1;
      end
      c_WRITE: begin
        // Address held so the RAM keeps presenting the byte fetched in READ.
        wram_en  = 1'b1;
        oam_wr   = 1'b1;
        oam_data = wram_dout;
      end
      default: begin
        wram_en = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma_ctrl
// Description : Directed, scoreboard-based bench for oam_dma_ctrl with a
//               behavioural synchronous WRAM model.
//               Honours DMA_ODD_ALIGN_EN for the expected busy length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_ctrl;

`ifdef DMA_ODD_ALIGN_EN
  localparam int ODD_BUSY = 514;
`else
  localparam int ODD_BUSY = 513;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wram_en;
  logic        cpu_rw;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        dma_start;
  logic [7:0]  dma_page;
  logic        wram_en;
  logic        wram_rw;
  logic [10:0] wram_addr;
  logic [7:0]  wram_din;
  logic [7:0]  wram_dout;
  logic        cpu_rdy;
  logic        dma_busy;
  logic        dma_err;
  logic        oam_wr;
  logic [7:0]  oam_data;

  logic [7:0]  mem [0:2047];
  logic [7:0]  exp_q [$];

  int          vec = 0;
  int          miss = 0;
  int          oam_cnt = 0;
  int          err_cnt = 0;
  int          rdy_low = 0;
  int          busy_wr = 0;
  int          extra = 0;
  int unsigned cyc;

  always #5 clk = ~clk;

  oam_dma_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_wram_en(cpu_wram_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .dma_start(dma_start), .dma_page(dma_page),
    .wram_en(wram_en), .wram_rw(wram_rw), .wram_addr(wram_addr), .wram_din(wram_din),
    .wram_dout(wram_dout),
    .cpu_rdy(cpu_rdy), .dma_busy(dma_busy), .dma_err(dma_err),
    .oam_wr(oam_wr), .oam_data(oam_data)
  );

  // Synchronous WRAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (wram_en) begin
      if (!wram_rw) mem[wram_addr] <= wram_din;
      else          wram_dout      <= mem[wram_addr];
    end
  end

  // Cycle count since reset release; its LSB is the expected parity.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: pops the scoreboard on each OAM write.
  always @(negedge clk) begin
    if (!rst) begin
      if (oam_wr) begin
        oam_cnt++;
        if (exp_q.size() == 0) extra++;
        else chk("oam_data", 32'(oam_data), 32'(exp_q.pop_front()));
      end
      if (dma_err)  err_cnt++;
      if (!cpu_rdy) rdy_low++;
      if (dma_busy && wram_en && !wram_rw) busy_wr++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    oam_cnt = 0; err_cnt = 0; rdy_low = 0; busy_wr = 0; extra = 0;
  endtask

  task automatic push_page_data();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ 8'h5A);
  endtask

  // Full transfer of a page mirroring $02; optionally pokes CPU writes and
  // extra starts while busy, which must have no effect.
  task automatic run_dma(input logic [7:0] page, input string tag, input bit poke);
    int exp_busy;
    clr_counts();
    push_page_data();
    exp_busy    = (((cyc + 1) % 2) == 1) ? ODD_BUSY : 513;
    dma_start   = 1'b1;
    dma_page    = page;
    step();
    dma_start   = 1'b0;
    if (poke) begin
      repeat (5) step();
      cpu_wram_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 11'h210; cpu_din = 8'hFF;
      dma_start   = 1'b1; dma_page = 8'h40;
      step();
      dma_page    = 8'h05;
      step();
      dma_start   = 1'b0; cpu_wram_en = 1'b0; cpu_rw = 1'b1;
    end
    for (int k = 0; k < 700 && dma_busy; k++) step();
    chk({tag, "_done"}, 32'(dma_busy), 32'd0);
    step();
    chk({tag, "_oamcnt"}, oam_cnt, 256);
    chk({tag, "_busylen"}, rdy_low, exp_busy);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_cpuwr"}, busy_wr, 0);
    chk({tag, "_extra"}, extra, 0);
    chk({tag, "_qleft"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_bad(input logic [7:0] page, input string tag);
    clr_counts();
    dma_start = 1'b1;
    dma_page  = page;
    step();
    dma_start = 1'b0;
    repeat (4) step();
    chk({tag, "_errpulse"}, err_cnt, 1);
    chk({tag, "_oamcnt"}, oam_cnt, 0);
    chk({tag, "_rdylow"}, rdy_low, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with CPU traffic and a start pending: pass-through, no DMA.
    rst = 1'b1; cpu_wram_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 11'h3C5; cpu_din = 8'h96;
    dma_start = 1'b1; dma_page = 8'h02;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_busy", 32'(dma_busy), 32'd0);
    chk("rst_oamwr", 32'(oam_wr), 32'd0);
    chk("rst_oamdata", 32'(oam_data), 32'd0);
    chk("rst_err", 32'(dma_err), 32'd0);
    chk("rst_wen", 32'(wram_en), 32'd1);
    chk("rst_wrw", 32'(wram_rw), 32'd0);
    chk("rst_waddr", 32'(wram_addr), 32'h3C5);
    chk("rst_wdin", 32'(wram_din), 32'h96);
    dma_start = 1'b0; cpu_wram_en = 1'b0; cpu_rw = 1'b1;
    rst = 1'b0;
    step();

    // Idle CPU write then read-back through the pass-through.
    cpu_wram_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 11'h123; cpu_din = 8'hA5;
    #1;
    chk("pt_wen", 32'(wram_en), 32'd1);
    chk("pt_wrw", 32'(wram_rw), 32'd0);
    chk("pt_waddr", 32'(wram_addr), 32'h123);
    chk("pt_wdin", 32'(wram_din), 32'hA5);
    step();
    cpu_rw = 1'b1;
    #1;
    chk("pt_rd_rw", 32'(wram_rw), 32'd1);
    step();
    cpu_wram_en = 1'b0;
    chk("pt_rdata", 32'(wram_dout), 32'hA5);

    // Preload page $02 through the CPU port.
    for (int i = 0; i < 256; i++) begin
      cpu_wram_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 11'h200 + 11'(i); cpu_din = 8'(i) ^ 8'h5A;
      step();
    end
    cpu_wram_en = 1'b0; cpu_rw = 1'b1;
    step();

    run_dma(8'h02, "p02", 1'b0);
    run_dma(8'h0A, "p0a_poke", 1'b1);
    run_dma(8'h1A, "p1a", 1'b0);
    run_bad(8'h40, "p40");
    run_bad(8'h20, "p20");

    // Reset after the 100th OAM write, then a clean full transfer.
    clr_counts();
    push_page_data();
    dma_start = 1'b1; dma_page = 8'h02;
    step();
    dma_start = 1'b0;
    for (int k = 0; k < 400 && oam_cnt < 100; k++) step();
    chk("mid_oam100", oam_cnt, 100);
    cpu_wram_en = 1'b1; cpu_rw = 1'b1; cpu_addr = 11'h7FF; cpu_din = 8'h3C;
    rst = 1'b1;
    #1;
    chk("mid_rdy", 32'(cpu_rdy), 32'd1);
    chk("mid_busy", 32'(dma_busy), 32'd0);
    chk("mid_oamwr", 32'(oam_wr), 32'd0);
    chk("mid_oamdata", 32'(oam_data), 32'd0);
    chk("mid_waddr", 32'(wram_addr), 32'h7FF);
    chk("mid_wen", 32'(wram_en), 32'd1);
    exp_q.delete();
    step();
    rst = 1'b0; cpu_wram_en = 1'b0;
    step();
    run_dma(8'h02, "post_rst", 1'b0);

    // Start on each parity.
    for (int k = 0; k < 4 && (cyc % 2) != 0; k++) step();
    run_dma(8'h02, "par_even", 1'b0);
    for (int k = 0; k < 4 && (cyc % 2) != 1; k++) step();
    run_dma(8'h02, "par_odd", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
